seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector. Runtime-loadable pattern of 1..SEQ_W bits, selectable overlapping or non-overlapping matching, and a qualified input strobe. Saturating match counter alongside the match pulse. Sits on a serial bit stream, one bit per valid cycle. Successor to the fixed 4-bit detector FSM: generalised in length and mode, with correct overlap handling for any pattern.

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/sat_counter.sv | 25 ++
 rtl/seq_detector_param.sv | 103 ++++++++++
 tb/tb_seq_detector_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector.
//   state_t    : detector state encoding (UNLOADED, HUNT)
//   DEF_SEQ_W  : default maximum pattern length
//   DEF_CNT_W  : default match counter width
//   clamp_len  : maps a requested pattern length onto 1..max_len
package seq_det_pkg;

    localparam int DEF_SEQ_W = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [0:0] {
        UNLOADED = 1'b0,
        HUNT     = 1'b1
    } state_t;

    // A length of 0 or larger than the pattern register selects the full width.
    function automatic int clamp_len(input int raw, input int max_len);
        if (raw == 0 || raw > max_len) begin
            return max_len;
        end
        return raw;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   clr   : synchronous active-high reset, highest priority
//   clear : synchronous clear to zero
//   inc   : increment request; the count holds at all-ones
//   q     : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr || clear) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern.
//   clk         : clock
//   clr         : synchronous active-high reset, dominates all inputs
//   E, E_valid  : serial data bit and its qualifier
//   load        : latch user_seq/seq_len/overlap and restart detection
//   user_seq    : pattern, bit [len-1] arrives first, bit [0] last
//   seq_len     : pattern length, 0 or oversize means SEQ_W
//   overlap     : 1 = overlapping matches, 0 = flush history after a match
//   Y           : registered one-cycle match pulse
//   match_count : saturating match count since clr/load
//   armed       : a pattern is loaded and detection is running
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int SEQ_W = DEF_SEQ_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         E,
    input  logic                         E_valid,
    input  logic                         load,
    input  logic [SEQ_W-1:0]             user_seq,
    input  logic [$clog2(SEQ_W+1)-1:0]   seq_len,
    input  logic                         overlap,
    output logic                         Y,
    output logic [CNT_W-1:0]             match_count,
    output logic                         armed
);

    localparam int              LEN_W = $clog2(SEQ_W + 1);
    localparam logic [LEN_W-1:0] FULL = LEN_W'(SEQ_W);

    state_t             state;
    logic [SEQ_W-1:0]   hist;
    logic [SEQ_W-1:0]   pat;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;
    logic               ovl;
    logic               y_r;

    logic               accept;
    logic               match;
    logic [SEQ_W:0]     shift_ext;
    logic [SEQ_W-1:0]   hist_nxt;
    logic [SEQ_W-1:0]   mask;
    logic [LEN_W-1:0]   fill_nxt;

    // A load cycle always discards the bit presented with it.
    always_comb begin
        accept    = (state == HUNT) && E_valid && !load;
        shift_ext = {hist, E};
        hist_nxt  = shift_ext[SEQ_W-1:0];
        fill_nxt  = (fill == FULL) ? fill : fill + 1'b1;
        mask      = '0;
        for (int i = 0; i < SEQ_W; i++) begin
            mask[i] = (i < int'(len));
        end
        // fill gates out matches built from bits older than the last load,
        // clr or non-overlapping match.
        match = accept && (fill_nxt >= len) &&
                (((hist_nxt ^ pat) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= UNLOADED;
            hist  <= '0;
            fill  <= '0;
            pat   <= '0;
            len   <= FULL;
            ovl   <= 1'b0;
            y_r   <= 1'b0;
        end else begin
            y_r <= match;
            if (load) begin
                state <= HUNT;
                pat   <= user_seq;
                len   <= LEN_W'(clamp_len(int'(seq_len), SEQ_W));
                ovl   <= overlap;
                hist  <= '0;
                fill  <= '0;
            end else if (accept) begin
                hist <= hist_nxt;
                fill <= (match && !ovl) ? '0 : fill_nxt;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .clr  (clr),
        .clear(load),
        .inc  (match),
        .q    (match_count)
    );

    assign Y     = y_r;
    assign armed = (state == HUNT);

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param. Three instances cover the
// SEQ_W=4, SEQ_W=8 and CNT_W=2 configurations; only one is driven at a time.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       clr;
    logic       E;
    logic [2:0] ev;
    logic [2:0] ld;
    logic [7:0] user_seq;
    logic [3:0] seq_len;
    logic       overlap;

    logic [2:0] y;
    logic [2:0] arm;
    logic [7:0] mc0, mc1;
    logic [1:0] mc2;
    int         mc [3];

    typedef struct {
        int id;
        int cnt;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.SEQ_W(4), .CNT_W(8)) d4 (
        .clk(clk), .clr(clr), .E(E), .E_valid(ev[0]), .load(ld[0]),
        .user_seq(user_seq[3:0]), .seq_len(seq_len[2:0]), .overlap(overlap),
        .Y(y[0]), .match_count(mc0), .armed(arm[0])
    );

    seq_detector_param #(.SEQ_W(8), .CNT_W(8)) d8 (
        .clk(clk), .clr(clr), .E(E), .E_valid(ev[1]), .load(ld[1]),
        .user_seq(user_seq), .seq_len(seq_len), .overlap(overlap),
        .Y(y[1]), .match_count(mc1), .armed(arm[1])
    );

    seq_detector_param #(.SEQ_W(4), .CNT_W(2)) dc (
        .clk(clk), .clr(clr), .E(E), .E_valid(ev[2]), .load(ld[2]),
        .user_seq(user_seq[3:0]), .seq_len(seq_len[2:0]), .overlap(overlap),
        .Y(y[2]), .match_count(mc2), .armed(arm[2])
    );

    always_comb begin
        mc[0] = int'(mc0);
        mc[1] = int'(mc1);
        mc[2] = int'(mc2);
    end

    // Monitor: every Y pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (y[k] === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse dut=%0d count=%0d required no pulse", k, mc[k]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.id != k || e.cnt != mc[k]) begin
                        n_err++;
                        $display("FAIL pulse dut=%0d count=%0d required dut=%0d count=%0d",
                                 k, mc[k], e.id, e.cnt);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pat(input int id, input logic [7:0] p, input logic [3:0] l,
                            input logic o);
        user_seq = p;
        seq_len  = l;
        overlap  = o;
        ld[id]   = 1'b1;
        cyc();
        ld       = '0;
        // Pattern inputs are ignored outside the load cycle.
        user_seq = ~p;
        seq_len  = l + 4'd1;
        overlap  = ~o;
    endtask

    // exp_cnt < 0 : no match expected for this bit.
    task automatic bit_in(input int id, input logic b, input logic v, input int exp_cnt);
        exp_t e;
        E      = b;
        ev[id] = v;
        if (exp_cnt >= 0) begin
            e.id  = id;
            e.cnt = exp_cnt;
            sb.push_back(e);
        end
        cyc();
        ev = '0;
    endtask

    task automatic drain(input string name);
        cyc();
        chk(name, sb.size(), 0);
    endtask

    initial begin
        clr = 1'b1; E = 1'b0; ev = '0; ld = '0;
        user_seq = '0; seq_len = '0; overlap = 1'b0;
        cyc(); cyc();
        clr = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("reset_armed", int'(arm[k]), 0);
            chk("reset_count", mc[k], 0);
        end
        // Bits before any load are ignored.
        bit_in(0, 1'b0, 1'b1, -1);
        chk("unloaded_count", mc[0], 0);

        // 0001 overlapping, 0,0,0,1,0,0,0,1
        load_pat(0, 8'b0001, 4'd4, 1'b1);
        chk("armed_after_load", int'(arm[0]), 1);
        bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 1, 1, 1);
        bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 1, 1, 2);
        chk("p0001_count", mc[0], 2);
        drain("p0001_queue");

        // 1010 overlapping
        load_pat(0, 8'b1010, 4'd4, 1'b1);
        chk("reload_clears_count", mc[0], 0);
        bit_in(0, 1, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 1, 1, -1);
        bit_in(0, 0, 1, 1);  bit_in(0, 1, 1, -1); bit_in(0, 0, 1, 2);
        chk("p1010_ovl_count", mc[0], 2);
        drain("p1010_ovl_queue");

        // 1010 non-overlapping
        load_pat(0, 8'b1010, 4'd4, 1'b0);
        bit_in(0, 1, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 1, 1, -1);
        bit_in(0, 0, 1, 1);  bit_in(0, 1, 1, -1); bit_in(0, 0, 1, -1);
        chk("p1010_novl_count", mc[0], 1);
        drain("p1010_novl_queue");

        // SEQ_W=8, len 3, junk upper pattern bits, invalid cycles carry inverted bits
        load_pat(1, 8'b10101110, 4'd3, 1'b0);
        bit_in(1, 1, 1, -1); bit_in(1, 0, 0, -1);
        bit_in(1, 1, 1, -1); bit_in(1, 0, 0, -1);
        bit_in(1, 0, 1, 1);  bit_in(1, 1, 0, -1);
        bit_in(1, 1, 1, -1); bit_in(1, 0, 0, -1);
        bit_in(1, 1, 1, -1); bit_in(1, 0, 0, -1);
        bit_in(1, 0, 1, 2);  bit_in(1, 1, 0, -1);
        chk("len3_count", mc[1], 2);
        drain("len3_queue");

        // clr mid-stream, with a valid bit presented alongside it
        load_pat(0, 8'b0001, 4'd4, 1'b1);
        bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1);
        clr = 1'b1;
        bit_in(0, 1, 1, -1);
        clr = 1'b0;
        chk("clr_armed", int'(arm[0]), 0);
        bit_in(0, 1, 1, -1);
        chk("clr_count", mc[0], 0);
        load_pat(0, 8'b0001, 4'd4, 1'b1);
        bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 1, 1, 1);
        chk("after_clr_count", mc[0], 1);
        drain("after_clr_queue");

        // load on a completing bit, then load-cycle bit must not count
        bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1);
        user_seq = 8'b0001; seq_len = 4'd4; overlap = 1'b1;
        E = 1'b1; ev[0] = 1'b1; ld[0] = 1'b1;
        cyc();
        ld = '0; ev = '0;
        chk("load_on_match_count", mc[0], 0);
        bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 1, 1, -1);
        bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 0, 1, -1); bit_in(0, 1, 1, 1);
        chk("load_discard_count", mc[0], 1);
        drain("load_discard_queue");

        // CNT_W=2, len 1, six consecutive ones
        load_pat(2, 8'b0001, 4'd1, 1'b1);
        bit_in(2, 1, 1, 1); bit_in(2, 1, 1, 2); bit_in(2, 1, 1, 3);
        bit_in(2, 1, 1, 3); bit_in(2, 1, 1, 3); bit_in(2, 1, 1, 3);
        bit_in(2, 0, 1, -1);
        chk("sat_count", mc[2], 3);
        drain("sat_queue");

        // seq_len=0 selects the full 4-bit length
        load_pat(0, 8'b1011, 4'd0, 1'b0);
        bit_in(0, 0, 1, -1); bit_in(0, 1, 1, -1); bit_in(0, 1, 1, -1);
        bit_in(0, 0, 1, -1); bit_in(0, 1, 1, -1); bit_in(0, 1, 1, 1);
        chk("len0_count", mc[0], 1);
        drain("len0_queue");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
